// File: rtl/mod_mapper_gen.sv
// Serial-bit to Q.10 I/Q constellation mapper (BPSK..256QAM) with ping-pong block addressing.
// Optional build macro: MOD_MAPPER_PAD_EN (zero-fill and emit a partial symbol at burst end).
module mod_mapper_gen #(
    parameter int OUT_WIDTH  = 18,
    parameter int ADDR_WIDTH = 11,
    parameter int MAX_SYMS   = 1200
) (
    input  logic                        CLK_Mod,
    input  logic                        RST_Mod,
    input  logic                        Valid_Mod_IN,
    output logic                        Ready_Mod,
    input  logic                        Bit_IN,
    input  logic [3:0]                  Order_Mod,
    input  logic [ADDR_WIDTH-1:0]       Block_Len,
    output logic signed [OUT_WIDTH-1:0] Mod_OUT_I,
    output logic signed [OUT_WIDTH-1:0] Mod_OUT_Q,
    output logic                        Mod_Valid_OUT,
    output logic                        write_enable,
    output logic [ADDR_WIDTH-1:0]       Wr_addr,
    output logic                        Bank_Sel,
    output logic                        MOD_DONE,
    output logic [ADDR_WIDTH-1:0]       Last_addr,
    output logic                        PINGPONG_SWITCH,
    output logic                        Order_Err
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_ERR} state_t;

    localparam logic [ADDR_WIDTH:0] LP_MAX = (ADDR_WIDTH + 1)'(MAX_SYMS);

    state_t                  r_state, w_state_nxt;
    logic [3:0]              r_cnt, w_cnt_nxt, r_order, w_order_cur;
    logic [7:0]              r_sym, w_sym_nxt, w_bits, r_s1_bits, w_load_bits;
    logic [ADDR_WIDTH-1:0]   r_blen, r_wr_addr, r_last;
    logic                    r_s1_valid, r_out_valid, r_bank, r_done, r_err;
    logic signed [OUT_WIDTH-1:0] r_out_i, r_out_q;
    logic                    w_ready, w_take, w_load, w_latch, w_err, w_flush_done;
    logic signed [11:0]      w_i, w_q;

    function automatic logic f_legal(input logic [3:0] ord);
        case (ord)
            4'd1, 4'd2, 4'd4, 4'd6, 4'd8: f_legal = 1'b1;
            default:                      f_legal = 1'b0;
        endcase
    endfunction

    // One axis of the constellation: a is the sign bit, c/d/e the nested amplitude bits.
    function automatic logic signed [11:0] f_axis(input logic [3:0] ord, input logic a,
                                                  input logic c, input logic d, input logic e);
        logic [3:0]  w2e, w2d, w4, mag;
        logic [10:0] fac;
        logic [11:0] p;
        w2e = e ? 4'd3 : 4'd1;
        w2d = d ? 4'd3 : 4'd1;
        w4  = d ? (4'd4 + w2e) : (4'd4 - w2e);
        case (ord)
            4'd4: begin mag = c ? 4'd3 : 4'd1;                   fac = 11'd324; end
            4'd6: begin mag = c ? (4'd4 + w2d) : (4'd4 - w2d);  fac = 11'd158; end
            4'd8: begin mag = c ? (4'd8 + w4) : (4'd8 - w4);    fac = 11'd79;  end
            default: begin mag = 4'd1;                           fac = 11'd724; end
        endcase
        p = {8'd0, mag} * {1'b0, fac};
        f_axis = a ? -$signed(p) : $signed(p);
    endfunction

    assign Ready_Mod       = w_ready;
    assign Mod_OUT_I       = r_out_i;
    assign Mod_OUT_Q       = r_out_q;
    assign Mod_Valid_OUT   = r_out_valid;
    assign write_enable    = r_out_valid;
    assign Wr_addr         = r_wr_addr;
    assign Bank_Sel        = r_bank;
    assign MOD_DONE        = r_done;
    assign PINGPONG_SWITCH = r_done;
    assign Last_addr       = r_last;
    assign Order_Err       = r_err;

    // Stage-1 symbol mapping feeding the registered outputs.
    always_comb begin
        w_i = f_axis(r_order, r_s1_bits[0], r_s1_bits[2], r_s1_bits[4], r_s1_bits[6]);
        w_q = f_axis(r_order, (r_order == 4'd1) ? r_s1_bits[0] : r_s1_bits[1],
                     r_s1_bits[3], r_s1_bits[5], r_s1_bits[7]);
    end

    // Next-state logic, bit collection and stage-1 load control.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_sym_nxt    = r_sym;
        w_load       = 1'b0;
        w_load_bits  = r_sym;
        w_latch      = 1'b0;
        w_err        = 1'b0;
        w_take       = 1'b0;
        w_flush_done = 1'b0;
        w_ready      = (r_state == ST_IDLE) || (r_state == ST_RUN);
        w_order_cur  = (r_state == ST_IDLE) ? Order_Mod : r_order;
        w_bits       = r_sym;
        w_bits[r_cnt[2:0]] = Bit_IN;
        case (r_state)
            ST_IDLE: begin
                if (Valid_Mod_IN && f_legal(Order_Mod)) begin
                    w_latch     = 1'b1;
                    w_take      = 1'b1;
                    w_state_nxt = ST_RUN;
                end else if (Valid_Mod_IN) begin
                    w_err       = 1'b1;
                    w_state_nxt = ST_ERR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (Valid_Mod_IN) begin
                    w_take = 1'b1;
                end else begin
`ifdef MOD_MAPPER_PAD_EN
                    w_load = (r_cnt != 4'd0);
`else
                    w_load = 1'b0;
`endif
                    w_cnt_nxt   = 4'd0;
                    w_sym_nxt   = 8'd0;
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!r_s1_valid && !r_out_valid) begin
                    w_flush_done = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_ERR: begin
                if (!Valid_Mod_IN) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ERR;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_take && (r_cnt + 4'd1 == w_order_cur)) begin
            w_load      = 1'b1;
            w_load_bits = w_bits;
            w_cnt_nxt   = 4'd0;
            w_sym_nxt   = 8'd0;
        end else if (w_take) begin
            w_cnt_nxt = r_cnt + 4'd1;
            w_sym_nxt = w_bits;
        end else begin
            w_cnt_nxt = w_cnt_nxt;
        end
    end

    // State, pipeline, addressing and block-close registers.
    always_ff @(posedge CLK_Mod) begin
        if (!RST_Mod) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_sym       <= 8'd0;
            r_order     <= 4'd0;
            r_blen      <= {ADDR_WIDTH{1'b0}};
            r_s1_valid  <= 1'b0;
            r_s1_bits   <= 8'd0;
            r_out_valid <= 1'b0;
            r_out_i     <= {OUT_WIDTH{1'b0}};
            r_out_q     <= {OUT_WIDTH{1'b0}};
            r_wr_addr   <= {ADDR_WIDTH{1'b0}};
            r_bank      <= 1'b0;
            r_done      <= 1'b0;
            r_last      <= {ADDR_WIDTH{1'b0}};
            r_err       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sym      <= w_sym_nxt;
            r_err      <= w_err;
            r_s1_valid <= w_load;
            r_done     <= 1'b0;
            if (w_latch) begin
                r_order <= Order_Mod;
                // Out-of-range lengths fall back to the largest legal block.
                r_blen  <= (Block_Len == {ADDR_WIDTH{1'b0}} || {1'b0, Block_Len} > LP_MAX)
                           ? LP_MAX[ADDR_WIDTH-1:0] : Block_Len;
            end
            if (w_load) begin
                r_s1_bits <= w_load_bits;
            end
            r_out_valid <= r_s1_valid;
            r_out_i     <= r_s1_valid ? {{(OUT_WIDTH-12){w_i[11]}}, w_i} : {OUT_WIDTH{1'b0}};
            r_out_q     <= r_s1_valid ? {{(OUT_WIDTH-12){w_q[11]}}, w_q} : {OUT_WIDTH{1'b0}};
            if (r_out_valid && (r_wr_addr == r_blen - {{(ADDR_WIDTH-1){1'b0}}, 1'b1})) begin
                r_wr_addr <= {ADDR_WIDTH{1'b0}};
                r_done    <= 1'b1;
                r_last    <= r_wr_addr;
                r_bank    <= ~r_bank;
            end else if (r_out_valid) begin
                r_wr_addr <= r_wr_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end else if (w_flush_done && (r_wr_addr != {ADDR_WIDTH{1'b0}})) begin
                r_wr_addr <= {ADDR_WIDTH{1'b0}};
                r_done    <= 1'b1;
                r_last    <= r_wr_addr - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                r_bank    <= ~r_bank;
            end else begin
                r_wr_addr <= r_wr_addr;
            end
        end
    end

endmodule

// File: tb/tb_mod_mapper_gen.sv
// Scoreboard bench for mod_mapper_gen: expected symbols and block closes are queued at drive time.
module tb_mod_mapper_gen;
    localparam int OW = 18;
    localparam int AW = 11;

    logic          clk, rst_n, valid, bit_in;
    logic [3:0]    order;
    logic [AW-1:0] blen;
    logic          ready, mvalid, we, bank, done, pps, oerr;
    logic signed [OW-1:0] oi, oq;
    logic [AW-1:0] wr_addr, last_addr;

    mod_mapper_gen #(.OUT_WIDTH(OW), .ADDR_WIDTH(AW), .MAX_SYMS(1200)) dut (
        .CLK_Mod(clk), .RST_Mod(rst_n), .Valid_Mod_IN(valid), .Ready_Mod(ready),
        .Bit_IN(bit_in), .Order_Mod(order), .Block_Len(blen),
        .Mod_OUT_I(oi), .Mod_OUT_Q(oq), .Mod_Valid_OUT(mvalid), .write_enable(we),
        .Wr_addr(wr_addr), .Bank_Sel(bank), .MOD_DONE(done), .Last_addr(last_addr),
        .PINGPONG_SWITCH(pps), .Order_Err(oerr)
    );

    typedef struct { int i; int q; int addr; int cyc; } sym_t;
    typedef struct { int last; int bank; int cyc; } done_t;

    sym_t  sym_q[$];
    done_t done_q[$];
    int n_tests = 0, n_fail = 0;
    int cyc = 0, err_seen = 0, exp_err = 0;
    int m_addr = 0, m_bank = 0, m_blen = 1200;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int ref_amp(input int ord, input logic [7:0] b, input bit qax);
        int s[8];
        int o;
        for (int k = 0; k < 8; k++) s[k] = 1 - 2 * int'(b[k]);
        o = qax ? 1 : 0;
        case (ord)
            1: return s[0] * 724;
            2: return s[o] * 724;
            4: return s[o] * (2 - s[2+o]) * 324;
            6: return s[o] * (4 - s[2+o] * (2 - s[4+o])) * 158;
            8: return s[o] * (8 - s[2+o] * (4 - s[4+o] * (2 - s[6+o]))) * 79;
            default: return 0;
        endcase
    endfunction

    task automatic push_sym(input int ord, input logic [7:0] b, input int c);
        sym_t s;
        done_t d;
        s.i = ref_amp(ord, b, 1'b0);
        s.q = ref_amp(ord, b, 1'b1);
        s.addr = m_addr;
        s.cyc = c;
        sym_q.push_back(s);
        m_addr++;
        if (m_addr == m_blen) begin
            m_bank = 1 - m_bank;
            d.last = m_blen - 1; d.bank = m_bank; d.cyc = c + 1;
            done_q.push_back(d);
            m_addr = 0;
        end
    endtask

    // chg >= 0 changes Order_Mod and Block_Len after the first bit of the burst.
    task automatic send_burst(input int ord, input int bl, input logic [63:0] bits,
                              input int nbits, input int chg);
        logic [7:0] sb;
        int k;
        bit legal;
        done_t d;
        sb = 8'd0; k = 0;
        legal = (ord == 1) || (ord == 2) || (ord == 4) || (ord == 6) || (ord == 8);
        m_blen = bl;
        for (int i = 0; i < nbits; i++) begin
            valid  = 1'b1;
            bit_in = bits[i];
            order  = (i >= 1 && chg >= 0) ? 4'(chg) : 4'(ord);
            blen   = (i >= 1 && chg >= 0) ? 11'd3 : AW'(bl);
            if (legal) begin
                sb[k] = bits[i];
                k++;
                if (k == ord) begin
                    push_sym(ord, sb, cyc + 2);
                    k = 0; sb = 8'd0;
                end
            end
            @(posedge clk); #1;
        end
        valid = 1'b0;
`ifdef MOD_MAPPER_PAD_EN
        if (legal && k > 0) push_sym(ord, sb, cyc + 2);
`endif
        if (legal && m_addr != 0) begin
            m_bank = 1 - m_bank;
            d.last = m_addr - 1; d.bank = m_bank; d.cyc = -1;
            done_q.push_back(d);
            m_addr = 0;
        end
        if (!legal) exp_err++;
        repeat (8) @(posedge clk);
        #1;
    endtask

    // Output monitor: sampled on the falling edge, popped against the scoreboard.
    always @(negedge clk) begin
        if (mvalid) begin
            if (sym_q.size() == 0) begin
                check("sym_unexpected", 1, 0);
            end else begin
                sym_t s;
                s = sym_q.pop_front();
                check("sym_i", int'(oi), s.i);
                check("sym_q", int'(oq), s.q);
                check("sym_addr", int'(wr_addr), s.addr);
                check("sym_cyc", cyc, s.cyc);
                check("sym_we", int'(we), 1);
            end
        end
        if (done) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", 1, 0);
            end else begin
                done_t d;
                d = done_q.pop_front();
                check("done_last", int'(last_addr), d.last);
                check("done_bank", int'(bank), d.bank);
                check("done_pps", int'(pps), 1);
                check("done_waddr", int'(wr_addr), 0);
                if (d.cyc >= 0) check("done_cyc", cyc, d.cyc);
            end
        end
        if (oerr) err_seen++;
    end

    initial begin
        rst_n = 1'b0; valid = 1'b0; bit_in = 1'b0; order = 4'd2; blen = 11'd1200;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", int'(ready), 1);
        check("rst_valid", int'(mvalid), 0);
        check("rst_bank", int'(bank), 0);
        check("rst_waddr", int'(wr_addr), 0);
        check("rst_done", int'(done), 0);
        check("rst_i", int'(oi), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        send_burst(2, 1200, 64'b10, 2, -1);
        send_burst(4, 1200, 64'b1101, 4, -1);
        send_burst(6, 1200, 64'b000000, 6, -1);
        send_burst(8, 1200, 64'h00, 8, -1);
        send_burst(8, 1200, 64'hFF, 8, -1);
        send_burst(1, 1200, 64'b101, 3, -1);
        send_burst(2, 4, {$urandom, $urandom}, 20, -1);
        send_burst(2, 4, {$urandom, $urandom}, 8, -1);
        check("coinc_waddr", int'(wr_addr), 0);

        send_burst(3, 1200, 64'b1011, 4, -1);
        check("err_count", err_seen, exp_err);
        check("err_ready", int'(ready), 1);

        send_burst(4, 1200, 64'hA5, 8, 2);
        send_burst(4, 1200, 64'b110000, 6, -1);

        if (m_bank == 0) send_burst(2, 1200, 64'b00, 2, -1);
        check("pre_rst_bank", int'(bank), 1);
        order = 4'd4; blen = 11'd1200; valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bit_in = 1'b1;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mrst_valid", int'(mvalid), 0);
        check("mrst_done", int'(done), 0);
        check("mrst_bank", int'(bank), 0);
        check("mrst_waddr", int'(wr_addr), 0);
        check("mrst_i", int'(oi), 0);
        check("mrst_q", int'(oq), 0);
        check("mrst_ready", int'(ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1; valid = 1'b0;
        m_bank = 0; m_addr = 0;
        repeat (8) @(posedge clk);
        #1;
        check("post_rst_bank", int'(bank), 0);
        send_burst(2, 1200, 64'b01, 2, -1);

        check("sym_q_empty", sym_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
